// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a 16-byte write FIFO
// Bit period is latched per frame from fsel; back-to-back frames have no idle gap.
module uart_tx #(
   parameter int FREQ_HZ   = 25_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fsel,
   input  logic       start,
   input  logic [7:0] data,
   output logic       rdy,
   output logic       busy,
   output logic       TxD
);

   localparam logic [11:0] LIMIT_SLOW = 12'(FREQ_HZ / BAUD_RATE);
   localparam logic [11:0] LIMIT_FAST = 12'(FREQ_HZ / (2 * BAUD_RATE));

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] tick_q, tick_d;
   logic [2:0]  bitcnt_q, bitcnt_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        txd_q, txd_d;
   logic        fsel_q, fsel_d;
   logic [3:0]  inptr_q, inptr_d;
   logic [3:0]  outptr_q, outptr_d;
   logic [4:0]  count_q, count_d;
   logic [7:0]  mem [16];

   logic [11:0] limit;
   logic        tick_last;
   logic        push;
   logic        pop;
   logic [7:0]  head;

   assign limit     = fsel_q ? LIMIT_FAST : LIMIT_SLOW;
   assign tick_last = (tick_q == (limit - 12'd1));
   assign head      = mem[outptr_q];

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         tick_q   <= 12'd0;
         bitcnt_q <= 3'd0;
         shreg_q  <= 8'd0;
         txd_q    <= 1'b1;
         fsel_q   <= 1'b0;
         inptr_q  <= 4'd0;
         outptr_q <= 4'd0;
         count_q  <= 5'd0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         txd_q    <= txd_d;
         fsel_q   <= fsel_d;
         inptr_q  <= inptr_d;
         outptr_q <= outptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[inptr_q] <= data;
      end
   end

   // Next-state logic; a pop always starts a new frame and latches the rate
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q + 12'd1;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      txd_d    = txd_q;
      fsel_d   = fsel_q;
      pop      = 1'b0;
      case (state_q)
         S_IDLE: begin
            tick_d = 12'd0;
            txd_d  = 1'b1;
            if (count_q != 5'd0) begin
               pop     = 1'b1;
               shreg_d = head;
               txd_d   = 1'b0;
               fsel_d  = fsel;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick_last) begin
               tick_d   = 12'd0;
               txd_d    = shreg_q[0];
               bitcnt_d = 3'd0;
               state_d  = S_DATA;
            end
         end
         S_DATA: begin
            if (tick_last) begin
               tick_d = 12'd0;
               if (bitcnt_q == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = S_STOP;
               end else begin
                  shreg_d  = shreg_q >> 1;
                  txd_d    = shreg_q[1];
                  bitcnt_d = bitcnt_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (tick_last) begin
               tick_d = 12'd0;
               if (count_q != 5'd0) begin
                  pop     = 1'b1;
                  shreg_d = head;
                  txd_d   = 1'b0;
                  fsel_d  = fsel;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      inptr_d  = push ? inptr_q + 4'd1 : inptr_q;
      outptr_d = pop ? outptr_q + 4'd1 : outptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
   end

   // Outputs; rdy comes from the registered count, so a full FIFO refuses even while popping
   always_comb begin
      rdy  = (count_q != 5'd16);
      busy = (state_q != S_IDLE) || (count_q != 5'd0);
      TxD  = txd_q;
      push = start && rdy;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
RS232 transmitter for 8-bit data, 8N1 framing: 1 start bit, 8 data bits LSB first, 1 stop bit. It is the transmit counterpart of the SoC's UART receiver and shares its baud parameters and `fsel` rate select. A 16-byte FIFO decouples the CPU's byte writes from serialisation. It sits on the same peripheral register slot as the receiver.

Parameters:
FREQ_HZ, 25_000_000, system clock frequency in Hz.
BAUD_RATE, 115_200, base baud rate. `fsel`=1 selects double rate.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  reset, synchronous, active-high.
fsel  input  1  rate select: 0 = BAUD_RATE, 1 = 2*BAUD_RATE.
start  input  1  write strobe; pushes `data` into the FIFO when `rdy`=1.
data  input  8  byte to transmit.
rdy  output  1  FIFO not full; a write is accepted this cycle.
busy  output  1  FIFO not empty or a frame in progress.
TxD  output  1  serial line; idles high.

Behaviour:
- Bit period LIMIT, in clocks:
  - fsel=0: LIMIT = FREQ_HZ/BAUD_RATE.
  - fsel=1: LIMIT = FREQ_HZ/(2*BAUD_RATE).
  - Integer division. 12-bit tick counter. LIMIT must be in 2..4095.
- Every bit, including start and stop, lasts exactly LIMIT clocks.
- One frame is 10*LIMIT clocks.
- `fsel` is latched when a frame starts. A change mid-frame affects the next frame only.
- FIFO:
  - 16 entries, 4-bit wrapping inptr/outptr, 5-bit count (0..16).
  - `rdy` = (count != 16).
  - Write when start & rdy. A `start` while full is dropped silently and state is unchanged.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - A full FIFO rejects a write even in the cycle a pop occurs, because `rdy` is registered from count.
  - Pointers wrap 15 -> 0.
- States: IDLE, START, DATA, STOP.
  - IDLE: TxD=1. If count != 0, pop the head byte into an 8-bit shreg, set TxD=0, clear tick, go to START. This happens on the same edge.
  - START: when tick reaches LIMIT-1, clear tick, set TxD=shreg[0], clear bitcnt, go to DATA.
  - DATA: on each tick=LIMIT-1, shift shreg right and bitcnt++.
    - TxD shows the next bit.
    - After bit 7 completes, set TxD=1 and go to STOP.
  - STOP: on tick=LIMIT-1, if count != 0, pop and go directly to START with TxD=0, with no idle gap. Otherwise go to IDLE.
- Latency: byte written at edge E into an empty FIFO while IDLE:
  - TxD falls at edge E+1.
  - TxD returns high (stop bit) at edge E+1+9*LIMIT.
  - `busy` drops at edge E+1+10*LIMIT.
- `busy` = (state != IDLE) | (count != 0). It is high from the edge after an accepted write.
- Reset, at any time including mid-frame, on the next edge:
  - state=IDLE, TxD=1, busy=0, rdy=1.
  - FIFO flushed (pointers and count = 0); tick, bitcnt and shreg cleared.
  - The partial frame is abandoned.
- Reset has priority over a simultaneous `start`: the write is lost.

Test Plan:
1. FREQ_HZ=1000, BAUD_RATE=100, fsel=0: write 0x55. TxD low at E+1 for 10 clocks, then 1,0,1,0,1,0,1,0 at 10 clocks each, then high 10 clocks. `busy` falls at E+101.
2. Same parameters, fsel=1: write 0xA3. Each bit is 5 clocks, sequence 0,1,1,0,0,0,1,0,1,1. Frame is 50 clocks.
3. Write 0x01, 0x02, 0x03 on consecutive cycles. Three frames back to back, 300 clocks total. The next start bit begins the clock right after each stop bit. `busy` stays high throughout.
4. Write 17 bytes 0x00..0x10 on consecutive cycles while the first frame starts:
   - The first byte is popped at E+1, so all 17 are accepted.
   - Repeat with line stalled on a full FIFO: `rdy`=0 at count 16 and the 17th write is dropped.
   - Transmitted order matches write order, with pointer wrap verified.
5. Assert `rst` for 1 clock mid-DATA of 0xFF with 3 bytes queued. Next edge: TxD=1, busy=0, rdy=1. No further frames are sent.
6. Toggle `fsel` 0->1 during a frame. The current frame keeps 10-clock bits; the next queued frame uses 5-clock bits.
